// File: rtl/bc_mem_responder.sv
// bc_mem_responder: 4096 x 16-bit main store for the basic computer.
// Serves CPU fetch/operand/store accesses over REQ/ACK with WAIT wait
// states, and accepts preload writes through a loader port while idle.
module bc_mem_responder #(
  parameter int unsigned WAIT = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WE,
  input  logic [11:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        ACK,
  output logic        BUSY,
  input  logic        LD_VALID,
  input  logic [11:0] LD_ADDR,
  input  logic [15:0] LD_DATA,
  output logic        LD_READY
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  // Main store; contents survive reset and are preloaded via the loader.
  logic [15:0] mem_q [4096];

  logic        mem_we_s;
  logic [11:0] mem_waddr_s;
  logic [15:0] mem_wdata_s;

  // Access being committed this edge (from ports when WAIT is zero,
  // otherwise from the latched request).
  logic        commit_s;
  logic [11:0] acc_addr_s;
  logic        acc_we_s;
  logic [15:0] acc_wdata_s;

  // Next-state, request latching, commit selection and memory write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_q;
    mem_wdata_s = wdata_q;
    commit_s    = 1'b0;
    acc_addr_s  = addr_q;
    acc_we_s    = we_q;
    acc_wdata_s = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (LD_VALID) begin
          // Loader wins over a simultaneous REQ; REQ is taken next edge.
          mem_we_s    = 1'b1;
          mem_waddr_s = LD_ADDR;
          mem_wdata_s = LD_DATA;
        end else if (REQ) begin
          addr_d  = ADDR;
          we_d    = WE;
          wdata_d = WDATA;
          cnt_d   = WAIT_CNT;
          if (WAIT_CNT != 4'd0) begin
            state_d = ST_WAIT;
          end else begin
            // No wait states: the sampling edge is also the commit edge.
            state_d     = ST_ACK;
            commit_s    = 1'b1;
            acc_addr_s  = ADDR;
            acc_we_s    = WE;
            acc_wdata_s = WDATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d    = 4'd0;
          state_d  = ST_ACK;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (commit_s) begin
      if (acc_we_s) begin
        mem_we_s    = 1'b1;
        mem_waddr_s = acc_addr_s;
        mem_wdata_s = acc_wdata_s;
      end else begin
        rdata_d = mem_q[acc_addr_s];
      end
    end else begin
      rdata_d = rdata_d;
    end
  end

  // Control and data registers, cleared asynchronously by RST_N.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 12'h000;
      we_q    <= 1'b0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory array write; suppressed while reset is held.
  always_ff @(posedge CLK) begin
    if (mem_we_s && RST_N) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign RDATA    = rdata_q;
  assign ACK      = (state_q == ST_ACK);
  assign BUSY     = (state_q != ST_IDLE);
  assign LD_READY = (state_q == ST_IDLE);

endmodule

// File: tb/tb_bc_mem_responder.sv
// Directed testbench for bc_mem_responder: WAIT=2, WAIT=0 and WAIT=3 instances.
module tb_bc_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  // WAIT = 2 instance
  logic req = 1'b0, we = 1'b0, ld_valid = 1'b0;
  logic [11:0] addr = 12'h000, ld_addr = 12'h000;
  logic [15:0] wdata = 16'h0000, ld_data = 16'h0000;
  logic [15:0] rdata;
  logic ack, busy, ld_ready;

  // WAIT = 0 instance
  logic req0 = 1'b0, we0 = 1'b0, ld_valid0 = 1'b0;
  logic [11:0] addr0 = 12'h000, ld_addr0 = 12'h000;
  logic [15:0] wdata0 = 16'h0000, ld_data0 = 16'h0000;
  logic [15:0] rdata0;
  logic ack0, busy0, ld_ready0;

  // WAIT = 3 instance
  logic req3 = 1'b0, we3 = 1'b0, ld_valid3 = 1'b0;
  logic [11:0] addr3 = 12'h000, ld_addr3 = 12'h000;
  logic [15:0] wdata3 = 16'h0000, ld_data3 = 16'h0000;
  logic [15:0] rdata3;
  logic ack3, busy3, ld_ready3;

  bc_mem_responder #(.WAIT(2)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .WE(we), .ADDR(addr), .WDATA(wdata),
    .RDATA(rdata), .ACK(ack), .BUSY(busy), .LD_VALID(ld_valid),
    .LD_ADDR(ld_addr), .LD_DATA(ld_data), .LD_READY(ld_ready)
  );

  bc_mem_responder #(.WAIT(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req0), .WE(we0), .ADDR(addr0), .WDATA(wdata0),
    .RDATA(rdata0), .ACK(ack0), .BUSY(busy0), .LD_VALID(ld_valid0),
    .LD_ADDR(ld_addr0), .LD_DATA(ld_data0), .LD_READY(ld_ready0)
  );

  bc_mem_responder #(.WAIT(3)) dut3 (
    .CLK(clk), .RST_N(rst_n), .REQ(req3), .WE(we3), .ADDR(addr3), .WDATA(wdata3),
    .RDATA(rdata3), .ACK(ack3), .BUSY(busy3), .LD_VALID(ld_valid3),
    .LD_ADDR(ld_addr3), .LD_DATA(ld_data3), .LD_READY(ld_ready3)
  );

  task automatic load2(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic load0(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid0 = 1'b1; ld_addr0 = a; ld_data0 = d;
    @(negedge clk);
    ld_valid0 = 1'b0;
  endtask

  task automatic load3(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid3 = 1'b1; ld_addr3 = a; ld_data3 = d;
    @(negedge clk);
    ld_valid3 = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ack); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (rdata !== 16'h0000) $display("FAIL reset_rdata got %h want 0000", rdata); else passed++;
    checks++; if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got %b want 1", ld_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loader_read();
    load2(12'h600, 16'h7653);
    req = 1'b1; we = 1'b0; addr = 12'h600;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (ack !== (k == 3)) $display("FAIL ldrd_ack cyc %0d got %b want %b", k, ack, (k == 3));
      else passed++;
      checks++;
      if (busy !== (k <= 3)) $display("FAIL ldrd_busy cyc %0d got %b want %b", k, busy, (k <= 3));
      else passed++;
      if (k == 1) begin
        checks++;
        if (ld_ready !== 1'b0) $display("FAIL ldrd_ld_ready got %b want 0", ld_ready); else passed++;
      end
      if (k == 3) begin
        checks++;
        if (rdata !== 16'h7653) $display("FAIL ldrd_rdata got %h want 7653", rdata); else passed++;
        req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midread();
    req = 1'b1; we = 1'b0; addr = 12'h600;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0) $display("FAIL rstmid_ack got %b want 0", ack); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
    checks++; if (rdata !== 16'h0000) $display("FAIL rstmid_rdata got %h want 0000", rdata); else passed++;
    checks++; if (ld_ready !== 1'b1) $display("FAIL rstmid_ld_ready got %b want 1", ld_ready); else passed++;
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b0) $display("FAIL rstmid_noack got %b want 0", ack); else passed++;
  endtask

  task automatic test_back_to_back();
    req = 1'b1; we = 1'b1; addr = 12'h700; wdata = 16'h3625;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (ack !== (k == 3 || k == 7))
        $display("FAIL b2b_ack cyc %0d got %b want %b", k, ack, (k == 3 || k == 7));
      else passed++;
      checks++;
      if (busy !== (k != 4)) $display("FAIL b2b_busy cyc %0d got %b want %b", k, busy, (k != 4));
      else passed++;
      if (k == 3) begin
        checks++;
        if (rdata !== 16'h0000) $display("FAIL b2b_wr_rdata got %h want 0000", rdata); else passed++;
        we = 1'b0;
      end
      if (k == 7) begin
        checks++;
        if (rdata !== 16'h3625) $display("FAIL b2b_rd_rdata got %h want 3625", rdata); else passed++;
        req = 1'b0;
      end
    end
  endtask

  task automatic test_zero_wait();
    load0(12'h101, 16'h7002);
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h101;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) $display("FAIL zw_ack got %b want 1", ack0); else passed++;
    checks++; if (busy0 !== 1'b1) $display("FAIL zw_busy got %b want 1", busy0); else passed++;
    checks++; if (rdata0 !== 16'h7002) $display("FAIL zw_rdata got %h want 7002", rdata0); else passed++;
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) $display("FAIL zw_ack_end got %b want 0", ack0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL zw_busy_end got %b want 0", busy0); else passed++;
  endtask

  task automatic test_simultaneous();
    ld_valid = 1'b1; ld_addr = 12'h100; ld_data = 16'h0600;
    req = 1'b1; we = 1'b0; addr = 12'h100;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (busy !== 1'b0) $display("FAIL sim_busy_after_ld got %b want 0", busy); else passed++;
        ld_valid = 1'b0;
      end
      checks++;
      if (ack !== (k == 4)) $display("FAIL sim_ack cyc %0d got %b want %b", k, ack, (k == 4));
      else passed++;
      if (k == 4) begin
        checks++;
        if (rdata !== 16'h0600) $display("FAIL sim_rdata got %h want 0600", rdata); else passed++;
        req = 1'b0;
      end
    end
  endtask

  task automatic test_abandoned_write();
    load3(12'hFFF, 16'h1234);
    req3 = 1'b1; we3 = 1'b1; addr3 = 12'hFFF; wdata3 = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy3 !== 1'b0) $display("FAIL abw_busy got %b want 0", busy3); else passed++;
    req3 = 1'b0; we3 = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (ack3 !== 1'b0) $display("FAIL abw_noack cyc %0d got %b want 0", k, ack3); else passed++;
    end
    req3 = 1'b1; we3 = 1'b0; addr3 = 12'hFFF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (ack3 !== (k == 4)) $display("FAIL abw_rd_ack cyc %0d got %b want %b", k, ack3, (k == 4));
      else passed++;
      if (k == 4) begin
        checks++;
        if (rdata3 !== 16'h1234) $display("FAIL abw_rdata got %h want 1234", rdata3); else passed++;
        req3 = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_loader_read();
    test_reset_midread();
    test_back_to_back();
    test_zero_wait();
    test_simultaneous();
    test_abandoned_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
